// File: rtl/univ_shift_reg.sv
// WIDTH-bit universal register: hold, shifts, rotates, load and invert, with async reset and sync clear.
// Each operation lands on the edge that samples it. en=0 holds q; msb_out/lsb_out/zero decode q directly.
module univ_shift_reg #(
  parameter int          WIDTH     = 8,
  parameter logic [63:0] RESET_VAL = 64'h0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_l,
  input  logic             sin_r,
  output logic [WIDTH-1:0] q,
  output logic             msb_out,
  output logic             lsb_out,
  output logic             zero
);

  if (WIDTH < 2 || WIDTH > 64) begin : g_width_chk
    $error("univ_shift_reg: WIDTH must be in 2..64");
  end

  localparam logic [WIDTH-1:0] LP_RST = RESET_VAL[WIDTH-1:0];

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_SHL  = 3'b001;
  localparam logic [2:0] MODE_SHR  = 3'b010;
  localparam logic [2:0] MODE_ROL  = 3'b011;
  localparam logic [2:0] MODE_ROR  = 3'b100;
  localparam logic [2:0] MODE_LOAD = 3'b101;
  localparam logic [2:0] MODE_ASR  = 3'b110;
  localparam logic [2:0] MODE_INV  = 3'b111;

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_nxt;

  // Serial inputs only matter for the two plain shifts; everything else is self-contained.
  always_comb begin
    w_nxt = r_q;
    case (mode)
      MODE_HOLD: w_nxt = r_q;
      MODE_SHL:  w_nxt = {r_q[WIDTH-2:0], sin_l};
      MODE_SHR:  w_nxt = {sin_r, r_q[WIDTH-1:1]};
      MODE_ROL:  w_nxt = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
      MODE_ROR:  w_nxt = {r_q[0], r_q[WIDTH-1:1]};
      MODE_LOAD: w_nxt = d;
      MODE_ASR:  w_nxt = {r_q[WIDTH-1], r_q[WIDTH-1:1]};
      MODE_INV:  w_nxt = ~r_q;
      default:   w_nxt = r_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= LP_RST;
    end else if (clr) begin
      r_q <= LP_RST;
    end else if (en) begin
      r_q <= w_nxt;
    end
  end

  assign q       = r_q;
  assign msb_out = r_q[WIDTH-1];
  assign lsb_out = r_q[0];
  assign zero    = (r_q == '0);

endmodule
